// File: rtl/simmem_pkg.sv
// Shared defaults and the delay-entry payload type for the simulated memory controller.
package simmem_pkg;

   localparam int unsigned NumChannelsDefault       = 2;
   localparam int unsigned ChannelCapacityDefault   = 64;
   localparam int unsigned DelayBankCapacityDefault = 64;
   localparam int unsigned CounterWidthDefault      = 16;
   localparam int unsigned ChanIdWidthDefault       = 1;
   localparam int unsigned LocalIdWidthDefault      = 6;

   // Delay entry at default widths; the bank builds a parameter-sized twin of this layout.
   typedef struct packed {
      logic                           valid;
      logic [ChanIdWidthDefault-1:0]  chan_id;
      logic [LocalIdWidthDefault-1:0] local_id;
      logic [CounterWidthDefault-1:0] counter;
   } delay_entry_t;

   // Channel id width, never narrower than one bit.
   function automatic int unsigned chan_id_width(input int unsigned num_channels);
      return (num_channels > 1) ? $clog2(num_channels) : 1;
   endfunction

endpackage

// File: rtl/simmem_lsb_onehot.sv
// Lowest-set-bit picker: returns a one-hot vector of the lowest set request bit (zero if none).
module simmem_lsb_onehot #(
   parameter int unsigned Width = 8
) (
   input  logic [Width-1:0] req_i,
   output logic [Width-1:0] onehot_o
);

   // Two's-complement trick isolates the lowest set bit.
   assign onehot_o = req_i & (~req_i + Width'(1));

endmodule

// File: rtl/simmem_delay_bank_mc.sv
// Multi-channel delay bank: holds tagged release requests for their delay, then raises
// sticky per-channel release enables until the downstream bank acknowledges them.
module simmem_delay_bank_mc
   import simmem_pkg::*;
#(
   parameter int unsigned NumChannels       = NumChannelsDefault,
   parameter int unsigned ChannelCapacity   = ChannelCapacityDefault,
   parameter int unsigned DelayBankCapacity = DelayBankCapacityDefault,
   parameter int unsigned CounterWidth      = CounterWidthDefault,
   localparam int unsigned ChanIdWidth      = chan_id_width(NumChannels),
   localparam int unsigned LocalIdWidth     = $clog2(ChannelCapacity),
   localparam int unsigned OccWidth         = $clog2(DelayBankCapacity + 1),
   localparam int unsigned RelWidth         = NumChannels * ChannelCapacity
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [ChanIdWidth-1:0]  channel_i,
   input  logic [LocalIdWidth-1:0] local_identifier_i,
   input  logic [CounterWidth-1:0] delay_i,
   input  logic                    freeze_i,
   input  logic [RelWidth-1:0]     released_onehot_i,
   output logic [RelWidth-1:0]     release_en_o,
   output logic [OccWidth-1:0]     occupancy_o
);

   localparam int unsigned NumEntries = DelayBankCapacity;

   typedef struct packed {
      logic                    valid;
      logic [ChanIdWidth-1:0]  chan_id;
      logic [LocalIdWidth-1:0] local_id;
      logic [CounterWidth-1:0] counter;
   } entry_t;

   entry_t                entries_q [NumEntries];
   entry_t                entries_d [NumEntries];
   logic [RelWidth-1:0]   release_en_q, release_en_d;
   logic [OccWidth-1:0]   occupancy_q, occupancy_d;

   logic [NumEntries-1:0] free_vec;
   logic [NumEntries-1:0] alloc_oh;
   logic [NumEntries-1:0] expired_vec [NumChannels];
   logic [NumEntries-1:0] select_oh   [NumChannels];
   logic [NumEntries-1:0] select_any;
   logic [RelWidth-1:0]   release_set;
   logic                  accept;
   logic                  chan_ok;
   logic                  dup_live;

   // Free map from registered valids only, so a slot freed this cycle is not reusable yet.
   always_comb begin
      for (int i = 0; i < NumEntries; i++) begin
         free_vec[i] = ~entries_q[i].valid;
      end
   end

   assign in_ready_o = |free_vec;
   assign accept     = in_valid_i && in_ready_o;

   simmem_lsb_onehot #(.Width(NumEntries)) u_alloc (
      .req_i    (free_vec),
      .onehot_o (alloc_oh)
   );

   // Requests naming a channel that does not exist are consumed without allocating.
   always_comb begin
      chan_ok = 1'b0;
      for (int c = 0; c < NumChannels; c++) begin
         if (channel_i == ChanIdWidth'(c)) chan_ok = 1'b1;
      end
   end

   // Per-channel map of entries whose countdown has reached zero.
   always_comb begin
      for (int c = 0; c < NumChannels; c++) begin
         for (int i = 0; i < NumEntries; i++) begin
            expired_vec[c][i] = entries_q[i].valid && (entries_q[i].counter == '0) &&
                                (entries_q[i].chan_id == ChanIdWidth'(c));
         end
      end
   end

   for (genvar c = 0; c < NumChannels; c++) begin : g_sel
      simmem_lsb_onehot #(.Width(NumEntries)) u_sel (
         .req_i    (expired_vec[c]),
         .onehot_o (select_oh[c])
      );
   end

   // Merge channel selections and decode them into release-enable set bits.
   always_comb begin
      select_any  = '0;
      release_set = '0;
      for (int c = 0; c < NumChannels; c++) begin
         select_any = select_any | select_oh[c];
         for (int i = 0; i < NumEntries; i++) begin
            if (select_oh[c][i]) begin
               release_set[c*ChannelCapacity +: ChannelCapacity] =
                  release_set[c*ChannelCapacity +: ChannelCapacity] |
                  (ChannelCapacity'(1) << entries_q[i].local_id);
            end
         end
      end
   end

   // Entry update: countdown (unless frozen), retire selected entries, load the allocated one.
   always_comb begin
      for (int i = 0; i < NumEntries; i++) begin
         entries_d[i] = entries_q[i];
         if (entries_q[i].valid && (entries_q[i].counter != '0) && !freeze_i) begin
            entries_d[i].counter = entries_q[i].counter - CounterWidth'(1);
         end
         if (select_any[i]) begin
            entries_d[i].valid = 1'b0;
         end
         if (accept && chan_ok && alloc_oh[i]) begin
            entries_d[i].valid    = 1'b1;
            entries_d[i].chan_id  = channel_i;
            entries_d[i].local_id = local_identifier_i;
            entries_d[i].counter  = delay_i;
         end
      end
   end

   // Sticky enables cleared by downstream acks; a new set in the same cycle wins.
   always_comb begin
      release_en_d = (release_en_q & ~released_onehot_i) | release_set;
      occupancy_d  = '0;
      for (int i = 0; i < NumEntries; i++) begin
         occupancy_d = occupancy_d + OccWidth'(entries_d[i].valid);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumEntries; i++) begin
            entries_q[i] <= '0;
         end
         release_en_q <= '0;
         occupancy_q  <= '0;
      end else begin
         for (int i = 0; i < NumEntries; i++) begin
            entries_q[i] <= entries_d[i];
         end
         release_en_q <= release_en_d;
         occupancy_q  <= occupancy_d;
      end
   end

   assign release_en_o = release_en_q;
   assign occupancy_o  = occupancy_q;

   // Detect an incoming request that duplicates a live (channel, local id) pair.
   always_comb begin
      dup_live = 1'b0;
      for (int i = 0; i < NumEntries; i++) begin
         if (entries_q[i].valid && (entries_q[i].chan_id == channel_i) &&
             (entries_q[i].local_id == local_identifier_i)) begin
            dup_live = 1'b1;
         end
      end
   end

   // Simulation checks on accepted requests.
   always_ff @(posedge clk_i) begin
      if (!rst_i && accept) begin
         assert (chan_ok)
            else $error("simmem_delay_bank_mc: request for nonexistent channel %0d", channel_i);
         assert (!dup_live)
            else $error("simmem_delay_bank_mc: duplicate live pair ch=%0d id=%0d",
                        channel_i, local_identifier_i);
      end
   end

endmodule

// File: tb/tb_simmem_delay_bank_mc.sv
// Bench for simmem_delay_bank_mc: directed scenarios plus a randomized run, all against a
// timestamp-based reference model of the delay bank.
module tb_simmem_delay_bank_mc;

   localparam int NC = 2;
   localparam int CC = 64;
   localparam int NE = 64;
   localparam int RW = NC * CC;

   logic           clk = 1'b0;
   logic           rst_i;
   logic           in_valid_i;
   logic           in_ready_o;
   logic [0:0]     channel_i;
   logic [5:0]     local_identifier_i;
   logic [15:0]    delay_i;
   logic           freeze_i;
   logic [RW-1:0]  released_onehot_i;
   logic [RW-1:0]  release_en_o;
   logic [6:0]     occupancy_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   simmem_delay_bank_mc dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .in_valid_i         (in_valid_i),
      .in_ready_o         (in_ready_o),
      .channel_i          (channel_i),
      .local_identifier_i (local_identifier_i),
      .delay_i            (delay_i),
      .freeze_i           (freeze_i),
      .released_onehot_i  (released_onehot_i),
      .release_en_o       (release_en_o),
      .occupancy_o        (occupancy_o)
   );

   // Reference model: each slot stores the unfrozen-cycle count at which it becomes due.
   bit          s_valid [NE];
   int          s_chan  [NE];
   int          s_id    [NE];
   longint      s_due   [NE];
   longint      tcount = 0;
   logic [RW-1:0] m_rel = '0;
   int          m_occ = 0;

   function automatic bit m_ready();
      for (int i = 0; i < NE; i++) if (!s_valid[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_live(input int ch, input int id);
      for (int i = 0; i < NE; i++)
         if (s_valid[i] && s_chan[i] == ch && s_id[i] == id) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      logic [RW-1:0] setv;
      int            free_idx;
      if (rst_i) begin
         for (int i = 0; i < NE; i++) s_valid[i] = 1'b0;
         m_rel = '0;
         m_occ = 0;
         return;
      end
      free_idx = -1;
      for (int i = 0; i < NE; i++) if (!s_valid[i] && free_idx < 0) free_idx = i;
      setv = '0;
      for (int c = 0; c < NC; c++) begin
         for (int i = 0; i < NE; i++) begin
            if (s_valid[i] && s_chan[i] == c && tcount >= s_due[i]) begin
               setv[c*CC + s_id[i]] = 1'b1;
               s_valid[i] = 1'b0;
               break;
            end
         end
      end
      m_rel = (m_rel & ~released_onehot_i) | setv;
      if (in_valid_i && free_idx >= 0) begin
         s_valid[free_idx] = 1'b1;
         s_chan[free_idx]  = int'(channel_i);
         s_id[free_idx]    = int'(local_identifier_i);
         s_due[free_idx]   = tcount + (freeze_i ? 0 : 1) + longint'(delay_i);
      end
      if (!freeze_i) tcount++;
      m_occ = 0;
      for (int i = 0; i < NE; i++) if (s_valid[i]) m_occ++;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid_i = 1'b0;
      channel_i = '0;
      local_identifier_i = '0;
      delay_i = '0;
   endtask

   task automatic req(input int ch, input int id, input int d);
      in_valid_i = 1'b1;
      channel_i = 1'(ch);
      local_identifier_i = 6'(id);
      delay_i = 16'(d);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle();
      tick();
      tick();
      rst_i = 1'b0;
      total++; if (release_en_o !== '0) begin bad++; $display("FAIL reset_release_en got=%h want=0", release_en_o); end
      total++; if (occupancy_o !== 7'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy_o); end
      total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_o); end
   endtask

   task automatic test_single();
      bit exp_b;
      int exp_o;
      req(0, 5, 3);
      tick();
      idle();
      for (int k = 1; k <= 9; k++) begin
         exp_b = (k >= 5 && k <= 7);
         exp_o = (k <= 4) ? 1 : 0;
         total++; if (release_en_o[5] !== exp_b) begin bad++; $display("FAIL single_bit k=%0d got=%b want=%b", k, release_en_o[5], exp_b); end
         total++; if (occupancy_o !== 7'(exp_o)) begin bad++; $display("FAIL single_occ k=%0d got=%0d want=%0d", k, occupancy_o, exp_o); end
         total++; if (release_en_o !== m_rel) begin bad++; $display("FAIL single_model k=%0d got=%h want=%h", k, release_en_o, m_rel); end
         if (k == 7) released_onehot_i[5] = 1'b1;
         tick();
         released_onehot_i = '0;
      end
   endtask

   task automatic test_two_channel();
      req(0, 2, 0); tick();
      req(1, 7, 0); tick();
      idle();
      total++; if (release_en_o[2] !== 1'b1 || release_en_o[CC+7] !== 1'b0) begin bad++; $display("FAIL two_ch_c2 got=%b%b want=01", release_en_o[CC+7], release_en_o[2]); end
      tick();
      total++; if (release_en_o[2] !== 1'b1 || release_en_o[CC+7] !== 1'b1) begin bad++; $display("FAIL two_ch_c3 got=%b%b want=11", release_en_o[CC+7], release_en_o[2]); end
      released_onehot_i[2] = 1'b1; released_onehot_i[CC+7] = 1'b1;
      tick();
      released_onehot_i = '0;
      total++; if (release_en_o !== '0) begin bad++; $display("FAIL two_ch_ack got=%h want=0", release_en_o); end
      req(0, 10, 2); tick();
      req(0, 11, 1); tick();
      idle();
      tick();
      tick();
      total++; if (release_en_o[10] !== 1'b1 || release_en_o[11] !== 1'b0) begin bad++; $display("FAIL same_exp_first got=%b%b want=01", release_en_o[11], release_en_o[10]); end
      tick();
      total++; if (release_en_o[11] !== 1'b1) begin bad++; $display("FAIL same_exp_second got=%b want=1", release_en_o[11]); end
      total++; if (release_en_o !== m_rel) begin bad++; $display("FAIL same_exp_model got=%h want=%h", release_en_o, m_rel); end
      released_onehot_i[10] = 1'b1; released_onehot_i[11] = 1'b1;
      tick();
      released_onehot_i = '0;
   endtask

   task automatic test_freeze();
      bit e0, e1;
      req(0, 20, 5); tick();
      req(1, 21, 0); tick();
      idle();
      for (int k = 2; k <= 12; k++) begin
         freeze_i = (k >= 2 && k <= 5);
         e0 = (k >= 11);
         e1 = (k >= 3);
         total++; if (release_en_o[20] !== e0) begin bad++; $display("FAIL freeze_ch0 k=%0d got=%b want=%b", k, release_en_o[20], e0); end
         total++; if (release_en_o[CC+21] !== e1) begin bad++; $display("FAIL freeze_ch1 k=%0d got=%b want=%b", k, release_en_o[CC+21], e1); end
         tick();
      end
      freeze_i = 1'b0;
      released_onehot_i[20] = 1'b1; released_onehot_i[CC+21] = 1'b1;
      tick();
      released_onehot_i = '0;
   endtask

   task automatic test_set_clear_same();
      req(0, 30, 0); tick();
      idle();
      tick();
      total++; if (release_en_o[30] !== 1'b1) begin bad++; $display("FAIL setclr_first got=%b want=1", release_en_o[30]); end
      req(0, 30, 0); tick();
      idle();
      released_onehot_i[30] = 1'b1;
      tick();
      released_onehot_i = '0;
      total++; if (release_en_o[30] !== 1'b1) begin bad++; $display("FAIL setclr_set_wins got=%b want=1", release_en_o[30]); end
      released_onehot_i[30] = 1'b1;
      tick();
      released_onehot_i = '0;
      total++; if (release_en_o[30] !== 1'b0) begin bad++; $display("FAIL setclr_clear got=%b want=0", release_en_o[30]); end
   endtask

   task automatic test_fill();
      int accepted;
      for (int i = 0; i < NE; i++) begin
         total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready i=%0d got=%b want=1", i, in_ready_o); end
         req(i % 2, i / 2, 100);
         tick();
      end
      idle();
      total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b want=0", in_ready_o); end
      total++; if (occupancy_o !== 7'd64) begin bad++; $display("FAIL fill_full_occ got=%0d want=64", occupancy_o); end
      req(1, 40, 0);
      accepted = -1;
      for (int k = NE; k < 300; k++) begin
         if (in_ready_o === 1'b1) begin
            accepted = k;
            tick();
            break;
         end
         tick();
      end
      idle();
      total++; if (accepted != 102) begin bad++; $display("FAIL fill_held_accept got=%0d want=102", accepted); end
      total++; if (release_en_o[0] !== 1'b1) begin bad++; $display("FAIL fill_first_release got=%b want=1", release_en_o[0]); end
      released_onehot_i = '1;
      for (int k = 0; k < 120; k++) begin
         total++; if (release_en_o !== m_rel) begin bad++; $display("FAIL drain_rel k=%0d got=%h want=%h", k, release_en_o, m_rel); end
         total++; if (occupancy_o !== 7'(m_occ)) begin bad++; $display("FAIL drain_occ k=%0d got=%0d want=%0d", k, occupancy_o, m_occ); end
         tick();
      end
      released_onehot_i = '0;
      total++; if (occupancy_o !== 7'd0 || release_en_o !== '0) begin bad++; $display("FAIL drain_end occ=%0d rel=%h want 0/0", occupancy_o, release_en_o); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin req(0, 40 + i, 0); tick(); end
      for (int i = 0; i < 10; i++) begin req(1, i, 50); tick(); end
      idle();
      tick();
      tick();
      total++; if (occupancy_o !== 7'd10) begin bad++; $display("FAIL rstmid_pre_occ got=%0d want=10", occupancy_o); end
      total++; if ($countones(release_en_o) != 3) begin bad++; $display("FAIL rstmid_pre_rel got=%0d want=3", $countones(release_en_o)); end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      total++; if (release_en_o !== '0) begin bad++; $display("FAIL rstmid_rel got=%h want=0", release_en_o); end
      total++; if (occupancy_o !== 7'd0) begin bad++; $display("FAIL rstmid_occ got=%0d want=0", occupancy_o); end
      total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", in_ready_o); end
      for (int k = 0; k < 60; k++) begin
         total++; if (release_en_o !== '0) begin bad++; $display("FAIL rstmid_stale k=%0d got=%h want=0", k, release_en_o); end
         tick();
      end
   endtask

   task automatic test_random();
      int ch, id;
      for (int n = 0; n < 600; n++) begin
         total++; if (in_ready_o !== m_ready()) begin bad++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, in_ready_o, m_ready()); end
         total++; if (release_en_o !== m_rel) begin bad++; $display("FAIL rand_rel n=%0d got=%h want=%h", n, release_en_o, m_rel); end
         total++; if (occupancy_o !== 7'(m_occ)) begin bad++; $display("FAIL rand_occ n=%0d got=%0d want=%0d", n, occupancy_o, m_occ); end
         idle();
         if ($urandom_range(0, 99) < 60) begin
            ch = int'($urandom_range(0, 1));
            id = int'($urandom_range(0, 63));
            if (!m_live(ch, id)) req(ch, id, (n < 300) ? int'($urandom_range(0, 90)) : int'($urandom_range(0, 8)));
         end
         freeze_i = ($urandom_range(0, 99) < 15);
         released_onehot_i = {$urandom(), $urandom(), $urandom(), $urandom()} &
                             {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
      end
      idle();
      freeze_i = 1'b0;
      released_onehot_i = '0;
   endtask

   initial begin
      rst_i = 1'b1;
      in_valid_i = 1'b0;
      channel_i = '0;
      local_identifier_i = '0;
      delay_i = '0;
      freeze_i = 1'b0;
      released_onehot_i = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_two_channel();
      test_freeze();
      test_set_clear_same();
      test_fill();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
